fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port imem_req_o  output  1  meaning instruction memory request.
REQ-007 SHALL have port imem_addr_o  output  XLEN  meaning request address.
REQ-008 SHALL have port imem_gnt_i  input  1  meaning request accepted this cycle.
REQ-009 SHALL have port imem_rvalid_i  input  1  meaning response data valid; exactly one cycle after grant.
REQ-010 SHALL have port imem_rdata_i  input  XLEN  meaning fetched instruction.
REQ-011 SHALL have port redirect_i  input  1  meaning flush and restart fetch.
REQ-012 SHALL have port redirect_pc_i  input  XLEN  meaning new fetch address.
REQ-013 SHALL have port valid_o  output  1  meaning pc_o/ir_o hold a valid instruction.
REQ-014 SHALL have port ready_i  input  1  meaning decode consumes head this cycle.
REQ-015 SHALL have port pc_o  output  XLEN  meaning PC of head instruction.
REQ-016 SHALL have port ir_o  output  XLEN  meaning head instruction.

Function
REQ-017 SHALL keep fetch_pc; imem_addr_o = fetch_pc.
REQ-018 SHALL assert imem_req_o when !redirect_i and count + pending - pop < DEPTH (pending = grant in previous cycle not yet dropped; pop = valid_o & ready_i; combinational ready_i path permitted).
REQ-019 SHALL advance fetch_pc by 4 (mod 2^XLEN, wrap-around) on imem_req_o & imem_gnt_i.
REQ-020 SHALL push {address of granted request, imem_rdata_i} on imem_rvalid_i unless dropped.
REQ-021 SHALL drive valid_o = (count != 0); pc_o/ir_o = head entry when valid, all-zero otherwise.
REQ-022 SHALL pop head on valid_o & ready_i; push and pop in one cycle leave count unchanged, FIFO order preserved, including at full.
REQ-023 SHALL never push when full (guaranteed by REQ-018); never pop when empty.
REQ-024 SHALL sustain one instruction per cycle with ready_i held high and imem_gnt_i=1, for any DEPTH >= 2.
REQ-025 SHALL on redirect_i: empty queue, fetch_pc <= redirect_pc_i, no request that cycle, drop the response arriving next cycle if a grant occurred this cycle; redirect overrides simultaneous push/pop.
REQ-026 SHALL issue first request to redirect_pc_i the cycle after redirect_i; back-to-back redirects: last one wins.
REQ-027 SHALL hold imem_req_o and imem_addr_o stable while imem_gnt_i=0 (no address change without grant except on redirect).

Reset
REQ-028 SHALL on rst_n=0 asynchronously set fetch_pc=RESET_PC, count=0, pointers=0, pending=0, drop flag=0.
REQ-029 SHALL while in reset and after it drive valid_o=0, pc_o=0, ir_o=0; imem_req_o SHALL be 0 during reset.
REQ-030 SHALL discard any in-flight response when reset asserts mid-operation; first request after deassertion is to RESET_PC.

Configuration
REQ-031 SHALL, with FETCH_QUEUE_STATS_EN defined, add output stall_cnt_o (32 bits), reset 0, incrementing (saturating at all-ones) each cycle ready_i=1 and valid_o=0, cleared by reset only.
REQ-032 SHALL, without FETCH_QUEUE_STATS_EN, have no stall_cnt_o port and no counter logic.

Verification
REQ-033 Reset release, gnt=1, ready=1, RESET_PC=0 -> addresses 0,4,8,...; valid_o from 2nd cycle after release, pc_o 0,4,8 on consecutive cycles.
REQ-034 DEPTH=4, ready=0, gnt=1 -> exactly 4 requests (0..0xC), imem_req_o low afterwards, count=4; ready=1 -> pc_o 0,4,8,0xC in order, requests resume at 0x10.
REQ-035 Redirect to 0x100 in cycle with grant of 0x8 -> 0x8 response dropped, queue empty, next output pc_o=0x100, next request 0x104.
REQ-036 fetch_pc=0xFFFFFFFC, gnt=1 -> next request address 0x00000000.
REQ-037 gnt=0 for 3 cycles -> imem_addr_o stable, no push; valid_o drops once queue drains.
REQ-038 rst_n low mid-stream with queue at 3 entries -> valid_o=0 immediately; after release first pc_o=RESET_PC; with FETCH_QUEUE_STATS_EN, stall_cnt_o=0 after reset and counts empty ready-high cycles.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests to instruction
// memory, buffers the returned {pc, instruction} pairs in a DEPTH-entry FIFO
// and hands them to decode with a valid/ready handshake. A redirect flushes
// the queue and restarts fetch at a new address.
//
// Optional build feature: define FETCH_QUEUE_STATS_EN to add a 32-bit
// saturating stall counter output (stall_cnt_o).
module fetch_queue #(
    parameter int unsigned        XLEN     = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [XLEN-1:0]    RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    // Instruction memory request/response
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    // Control flow redirect
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    // Decode side
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ir_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough to hold count + pending without overflow
    localparam int unsigned CW = AW + 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pend_addr;   // address of the request granted last cycle
    logic            r_pending;     // a response is due this cycle and will be kept
    logic            r_drop;        // the response due this cycle must be discarded
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;

    logic [XLEN-1:0] r_pc_mem [DEPTH];
    logic [XLEN-1:0] r_ir_mem [DEPTH];

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic            w_pop;
    logic            w_push;
    logic            w_grant;
    logic [CW-1:0]   w_occ;

    // Head presentation and handshake decode
    always_comb begin
        valid_o = (r_count != '0);
        pc_o    = '0;
        ir_o    = '0;
        if (valid_o) begin
            pc_o = r_pc_mem[r_rd_ptr];
            ir_o = r_ir_mem[r_rd_ptr];
        end
        w_pop  = valid_o & ready_i;
        // A redirect discards whatever arrives in the same cycle
        w_push = imem_rvalid_i & ~r_drop & ~redirect_i;
    end

    // Request generation: only request when the response is guaranteed a slot.
    // Occupancy after this cycle = count + pending - pop; the pop term lets a
    // full queue keep streaming when decode drains it in the same cycle.
    always_comb begin
        w_occ       = CW'(r_count) + CW'(r_pending) - CW'(w_pop);
        // rst_n gating keeps the request low while reset is held
        imem_req_o  = rst_n & ~redirect_i & (w_occ < CW'(DEPTH));
        imem_addr_o = r_fetch_pc;
        w_grant     = imem_req_o & imem_gnt_i;
    end

    // Fetch PC, in-flight tracking and FIFO pointers/count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_pend_addr <= '0;
            r_pending   <= 1'b0;
            r_drop      <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else if (redirect_i) begin
            r_fetch_pc  <= redirect_pc_i;
            r_pending   <= 1'b0;
            // Any grant seen in the redirect cycle belongs to the old stream
            r_drop      <= imem_gnt_i;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_grant) begin
                r_fetch_pc  <= r_fetch_pc + XLEN'(4);
                r_pend_addr <= r_fetch_pc;
            end
            r_pending <= w_grant;
            r_drop    <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr] <= r_pend_addr;
            r_ir_mem[r_wr_ptr] <= imem_rdata_i;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where decode is ready but nothing is available; saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (ready_i && !valid_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
